// File: rtl/alu_seq.sv
// Registered ALU with a valid/ready input handshake: single-cycle simple ops plus
// WIDTH-cycle iterative unsigned multiply (shift-add) and divide (restoring).
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       cl,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic [4:0]       flags
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;
  localparam logic [3:0] OP_ROL   = 4'd8;
  localparam logic [3:0] OP_ROR   = 4'd9;
  localparam logic [3:0] OP_INC   = 4'd10;
  localparam logic [3:0] OP_DEC   = 4'd11;
  localparam logic [3:0] OP_MUL   = 4'd12;
  localparam logic [3:0] OP_DIV   = 4'd13;
  localparam logic [3:0] OP_SLT   = 4'd14;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             isDiv_q;
  logic [WIDTH-1:0] opA_q, opB_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] out_q, outHi_q;
  logic [4:0]       flags_q;
  logic             outValid_q;

  logic             accept, isLong, lastIter;

  logic [WIDTH-1:0] opnd2;
  logic [WIDTH:0]   addSum;
  logic [WIDTH-1:0] subRes;
  logic [WIDTH-1:0] simpleRes;
  logic             simpleCarry, simpleOvf;

  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic             divGe;
  logic [WIDTH-1:0] iterHi, iterLo;
  logic             longDz;
  logic [WIDTH-1:0] longRes, longHi;

  assign accept   = in_valid & in_ready;
  assign isLong   = (cl == OP_MUL) || (cl == OP_DIV);
  assign lastIter = (state_q == BUSY) && (cnt_q == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && isLong) state_d = BUSY;
      BUSY: if (lastIter)         state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) & ~rst;
    out_valid = outValid_q;
    out       = out_q;
    out_hi    = outHi_q;
    flags     = flags_q;
  end

  // INC/DEC reuse the ADD/SUB paths with a constant second operand.
  always_comb begin
    opnd2       = ((cl == OP_INC) || (cl == OP_DEC)) ? WIDTH'(1) : b;
    addSum      = {1'b0, a} + {1'b0, opnd2};
    subRes      = a - opnd2;
    simpleRes   = '0;
    simpleCarry = 1'b0;
    simpleOvf   = 1'b0;
    case (cl)
      OP_ADD, OP_INC: begin
        simpleRes   = addSum[WIDTH-1:0];
        simpleCarry = addSum[WIDTH];
        simpleOvf   = (a[WIDTH-1] == opnd2[WIDTH-1]) && (addSum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        simpleRes   = subRes;
        simpleCarry = a < opnd2;
        simpleOvf   = (a[WIDTH-1] != opnd2[WIDTH-1]) && (subRes[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: simpleRes = a & b;
      OP_OR:  simpleRes = a | b;
      OP_XOR: simpleRes = a ^ b;
      OP_NOT: simpleRes = ~a;
      OP_SHL: begin
        simpleRes   = {a[WIDTH-2:0], 1'b0};
        simpleCarry = a[WIDTH-1];
      end
      OP_SHR: begin
        simpleRes   = {1'b0, a[WIDTH-1:1]};
        simpleCarry = a[0];
      end
      OP_ROL: begin
        simpleRes   = {a[WIDTH-2:0], a[WIDTH-1]};
        simpleCarry = a[WIDTH-1];
      end
      OP_ROR: begin
        simpleRes   = {a[0], a[WIDTH-1:1]};
        simpleCarry = a[0];
      end
      OP_SLT: simpleRes = WIDTH'($signed(a) < $signed(b));
      default: simpleRes = b;
    endcase
  end

  // hi_q:lo_q is the product accumulator for MUL and remainder:quotient for DIV.
  always_comb begin
    mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opB_q} : '0);
    divShift = {hi_q, lo_q[WIDTH-1]};
    divGe    = divShift >= {1'b0, opB_q};
    if (isDiv_q) begin
      iterHi = divGe ? (divShift[WIDTH-1:0] - opB_q) : divShift[WIDTH-1:0];
      iterLo = {lo_q[WIDTH-2:0], divGe};
    end else begin
      iterHi = mulSum[WIDTH:1];
      iterLo = {mulSum[0], lo_q[WIDTH-1:1]};
    end
    longDz  = isDiv_q && (opB_q == '0);
    longRes = longDz ? '1 : iterLo;
    longHi  = longDz ? opA_q : iterHi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      isDiv_q    <= 1'b0;
      opA_q      <= '0;
      opB_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      out_q      <= '0;
      outHi_q    <= '0;
      flags_q    <= '0;
      outValid_q <= 1'b0;
    end else begin
      outValid_q <= 1'b0;
      if (state_q == IDLE) begin
        if (accept && isLong) begin
          opA_q   <= a;
          opB_q   <= b;
          hi_q    <= '0;
          lo_q    <= a;
          cnt_q   <= CW'(WIDTH);
          isDiv_q <= (cl == OP_DIV);
        end else if (accept) begin
          out_q      <= simpleRes;
          outHi_q    <= '0;
          flags_q    <= {1'b0, simpleOvf, simpleCarry, simpleRes[WIDTH-1], simpleRes == '0};
          outValid_q <= 1'b1;
        end
      end else begin
        hi_q  <= iterHi;
        lo_q  <= iterLo;
        cnt_q <= cnt_q - CW'(1);
        if (lastIter) begin
          out_q      <= longRes;
          outHi_q    <= longHi;
          flags_q    <= {longDz, 1'b0, ~isDiv_q && (iterHi != '0),
                         longRes[WIDTH-1], longRes == '0};
          outValid_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the team's 8-bit combinational ALU. It keeps the same 16-entry 4-bit opcode space on `cl` and adds the following:
- a `WIDTH` parameter;
- a valid/ready input handshake;
- registered status flags;
- iterative unsigned multiply and divide, each taking `WIDTH` cycles.

It sits between an instruction/operand source and a result consumer. It accepts one simple op per cycle.

## Interface
- `WIDTH`, default 8: operand and result width. Legal values are 4..32.
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: reset. Synchronous, active-high.
- `in_valid`, in, 1: `a`, `b` and `cl` are valid this cycle.
- `in_ready`, out, 1: the block can accept an op. The op is taken on an edge where `in_valid & in_ready` is 1.
- `a`, in, `WIDTH`: operand A.
- `b`, in, `WIDTH`: operand B.
- `cl`, in, 4: opcode.
- `out_valid`, out, 1: one-cycle pulse marking a new result.
- `out`, out, `WIDTH`: primary result. Held until the next result.
- `out_hi`, out, `WIDTH`: MUL high half, or DIV remainder. It is 0 for all other ops.
- `flags`, out, 5: {dz, ovf, carry, neg, zero}. Held with `out`.

## Operation
- **Opcode map.** Arithmetic is modulo 2^WIDTH.
  - 0 ADD: a+b.
  - 1 SUB: a−b.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT: ~a.
  - 6 SHL: a<<1.
  - 7 SHR: a>>1, logical.
  - 8 ROL: rotate a left by 1.
  - 9 ROR: rotate a right by 1.
  - 10 INC: a+1.
  - 11 DEC: a−1.
  - 12 MUL: unsigned a*b. `out` is the low half, `out_hi` is the high half.
  - 13 DIV: unsigned a/b. `out` is the quotient, `out_hi` is the remainder.
  - 14 SLT: 1 if a<b signed, else 0.
  - 15 PASSB: b.
- **zero flag:** `out == 0`.
- **neg flag:** `out[WIDTH-1]`.
- **carry flag:**
  - ADD and INC: carry-out.
  - SUB and DEC: borrow, i.e. unsigned a < subtrahend.
  - SHL and ROL: bit shifted out of the MSB.
  - SHR and ROR: bit shifted out of the LSB.
  - MUL: 1 if `out_hi != 0`.
  - All other ops: 0.
- **ovf flag:** two's-complement signed overflow for ADD, SUB, INC and DEC. It is 0 for all other ops.
- **dz flag:** 1 only for DIV with b == 0. In that case `out` is all ones and `out_hi` is a.
- **FSM states:** IDLE and BUSY.
  - IDLE with a simple op accepted (any op except 12 and 13): the result registers on the accept edge and the FSM stays in IDLE.
  - IDLE with MUL or DIV accepted: operands load, the iteration counter loads `WIDTH`, and the FSM moves to BUSY. Outputs are unchanged.
  - BUSY: each edge performs one iteration and decrements the counter. MUL is shift-add; DIV is restoring, one quotient bit per edge.
  - On the edge where the counter reaches 0, the result and flags register, `out_valid` pulses, and the FSM returns to IDLE.
- **in_ready:** equals `(state == IDLE) & ~rst`. While `in_ready` is 0, `in_valid` is ignored and no op is queued.
- **No output backpressure.** A result is dropped if the consumer misses the `out_valid` pulse. `out`, `out_hi` and `flags` stay stable until the next result.
- **Reset:** `in_ready`=0, `out_valid`=0, `out`=0, `out_hi`=0, `flags`=0, state=IDLE, counter=0.
- **Reset during BUSY:** the operation is aborted. No `out_valid` is produced and outputs return to their reset values.

## Timing
- **Simple ops:** accepted at edge N. `out_valid`=1 in the cycle after edge N, i.e. a latency of 1. Throughput is 1 op per cycle with `in_valid` held high.
- **MUL and DIV:** accepted at edge N. The FSM is in BUSY for the `WIDTH` cycles following edge N, with `in_ready`=0. Iterations happen at edges N+1 through N+WIDTH.
- The MUL/DIV result and `out_valid` are visible after edge N+WIDTH. `in_ready`=1 in that same cycle, so a new op can be accepted while `out_valid` is high.
- The first cycle after `rst` deasserts has `in_ready`=1 and `out_valid`=0.
- When `rst` and `in_valid` are both high on the same edge, `rst` wins and the op is not accepted.

## Test plan
- **Reset values.** Hold `rst` for 2 cycles with `in_valid`=1 → `in_ready`=0, `out_valid`=0 and `out`=`out_hi`=`flags`=0 throughout. After release, `in_ready`=1.
- **Back-to-back simple ops** (WIDTH=8, a=100, b=50, `cl`=0, 1, 14, 15 on consecutive cycles):
  - ADD → `out`=150, ovf=1, neg=1, carry=0.
  - SUB → `out`=50, carry=0.
  - SLT → `out`=0, zero=1.
  - PASSB → `out`=50.
  - `out_valid` is high for 4 consecutive cycles.
- **Borrow and shift carries** (a=50, b=100):
  - SUB → `out`=206, carry=1, neg=1.
  - SHL of a=0x81 → `out`=0x02, carry=1.
  - ROR of a=0x01 → `out`=0x80, carry=1.
- **MUL** (a=100, b=50) → after exactly 8 BUSY cycles, `out`=0x88 (136), `out_hi`=0x13 (19), carry=1. `in_ready` is 0 for those 8 cycles, and an `in_valid` pulse during BUSY is ignored.
- **DIV:**
  - a=100, b=7 → `out`=14, `out_hi`=2, dz=0, latency 8.
  - a=100, b=0 → `out`=255, `out_hi`=100, dz=1.
  - An ADD issued in the `out_valid` cycle is accepted and its result appears on the next cycle.
- **Reset mid-MUL.** Assert `rst` on BUSY cycle 3 → no `out_valid`, outputs return to 0. A MUL issued after release completes normally with `out`=0x88.
